// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the TX channel arbiter: command codes, owner and
// state encodings, frame sizing and the payload-length helper.
package tx_arbiter_pkg;

  localparam int unsigned TX_CMD_BITS     = 2;
  localparam int unsigned NSHIFT          = TX_CMD_BITS;
  localparam int unsigned PAYLOAD_CYCLES  = 8;
  localparam int unsigned MAX_OUTSTANDING = 2;
  localparam int unsigned CNT_W           = $clog2(PAYLOAD_CYCLES) + 1;

  typedef logic [TX_CMD_BITS-1:0] cmd_t;
  typedef logic [NSHIFT-1:0]      data_t;
  typedef logic [CNT_W-1:0]       cnt_t;

  localparam cmd_t TX_HEADER_READ_16  = cmd_t'(1);
  localparam cmd_t TX_HEADER_WRITE_8  = cmd_t'(2);
  localparam cmd_t TX_HEADER_WRITE_16 = cmd_t'(3);

  typedef enum logic {
    OWNER_PF    = 1'b0,
    OWNER_SCHED = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // Short writes carry half a 16-bit payload; every other command is full length.
  function automatic cnt_t payload_len(input cmd_t cmd);
    if (cmd == TX_HEADER_WRITE_8) return cnt_t'(PAYLOAD_CYCLES / 2);
    return cnt_t'(PAYLOAD_CYCLES);
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester, TX pin and RX-owner signals of the arbiter; master is the
// requester/pin side, slave is the arbiter.
interface tx_arbiter_if;
  import tx_arbiter_pkg::*;

  logic  sched_cmd_valid;
  cmd_t  sched_cmd;
  logic  sched_reserve;
  logic  sched_reply_wanted;
  logic  sched_cmd_started;
  data_t sched_data;
  logic  sched_data_next;

  logic  pf_cmd_valid;
  logic  pf_cmd_started;
  data_t pf_data;
  logic  pf_data_next;

  data_t tx_pins;
  logic  tx_active;
  cnt_t  tx_counter;
  logic  tx_done;

  logic  rx_done;
  logic  rx_owner_valid;
  logic  rx_owner_sched;

  modport master (
    output sched_cmd_valid, sched_cmd, sched_reserve, sched_reply_wanted, sched_data,
    output pf_cmd_valid, pf_data, rx_done,
    input  sched_cmd_started, sched_data_next, pf_cmd_started, pf_data_next,
    input  tx_pins, tx_active, tx_counter, tx_done, rx_owner_valid, rx_owner_sched
  );

  modport slave (
    input  sched_cmd_valid, sched_cmd, sched_reserve, sched_reply_wanted, sched_data,
    input  pf_cmd_valid, pf_data, rx_done,
    output sched_cmd_started, sched_data_next, pf_cmd_started, pf_data_next,
    output tx_pins, tx_active, tx_counter, tx_done, rx_owner_valid, rx_owner_sched
  );

endinterface

// File: rtl/tx_owner_fifo.sv
// Owner FIFO for outstanding reads: one bit per entry (1 = scheduler).
// A pop on an empty FIFO is ignored; push and pop together keep the count.
module tx_owner_fifo
  import tx_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTSTANDING
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_data
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [FCNT_W-1:0] fcnt_t;

  logic  mem_q [DEPTH];
  logic  mem_d [DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  fcnt_t count_q, count_d;
  logic  push_ok, pop_ok;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full      = (count_q == fcnt_t'(DEPTH));
  assign empty     = (count_q == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem_q[rd_ptr_q];

  // NOTE: every variable gets its default at the top of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + fcnt_t'(1);
      2'b01:   count_d = count_q - fcnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it was written, and the head is qualified by !empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates scheduler and prefetch commands onto the serial TX channel and
// tracks read-reply owners. Define TX_ARB_ROUND_ROBIN_EN for alternating priority.
module tx_arbiter
  import tx_arbiter_pkg::*;
(
  input logic         clk,
  input logic         reset,
  tx_arbiter_if.slave bus
);

  state_e state_q, state_d;
  cnt_t   cnt_q,   cnt_d;
  cmd_t   cmd_q,   cmd_d;
  owner_e owner_q, owner_d;

  logic tx_done_w, arb_window, fifo_block;
  logic sched_ok, pf_ok, pick_pf;
  logic grant_sched, grant_pf;
  logic fifo_push, fifo_full, fifo_empty, fifo_head;

  assign tx_done_w  = (state_q == PAYLOAD) && (cnt_q == payload_len(cmd_q));
  assign arb_window = (state_q == IDLE) || tx_done_w;

  // A full FIFO only blocks reads when no reply retires in the same cycle.
  assign fifo_block = fifo_full && !bus.rx_done;
  assign sched_ok   = bus.sched_cmd_valid && (bus.sched_cmd != '0) &&
                      !((bus.sched_cmd == TX_HEADER_READ_16) && fifo_block);
  assign pf_ok      = bus.pf_cmd_valid && !bus.sched_reserve && !fifo_block;

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic rr_pf_pri_q, rr_pf_pri_d;

  always_comb begin
    rr_pf_pri_d = rr_pf_pri_q;
    if (grant_sched)   rr_pf_pri_d = 1'b1;
    else if (grant_pf) rr_pf_pri_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_pf_pri_q <= 1'b0;
    else       rr_pf_pri_q <= rr_pf_pri_d;
  end

  assign pick_pf = pf_ok && (!sched_ok || rr_pf_pri_q);
`else
  assign pick_pf = pf_ok && !sched_ok;
`endif

  assign grant_sched = arb_window && sched_ok && !pick_pf;
  assign grant_pf    = arb_window && pick_pf;
  assign fifo_push   = grant_pf ||
                       (grant_sched && (bus.sched_cmd == TX_HEADER_READ_16) && bus.sched_reply_wanted);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    owner_d = owner_q;
    if (grant_sched || grant_pf) begin
      state_d = HEADER;
      cnt_d   = '0;
      cmd_d   = grant_sched ? bus.sched_cmd : TX_HEADER_READ_16;
      owner_d = grant_sched ? OWNER_SCHED : OWNER_PF;
    end else begin
      case (state_q)
        HEADER: begin
          state_d = PAYLOAD;
          cnt_d   = cnt_t'(1);
        end
        PAYLOAD: begin
          if (tx_done_w) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      owner_q <= OWNER_PF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
    end
  end

  // Payload bits come straight from the owner so its data_next handshake sees no extra latency.
  always_comb begin
    bus.tx_pins = '0;
    case (state_q)
      HEADER:  bus.tx_pins = cmd_q;
      PAYLOAD: bus.tx_pins = (owner_q == OWNER_SCHED) ? bus.sched_data : bus.pf_data;
      default: ;
    endcase
  end

  assign bus.tx_active         = (state_q != IDLE);
  assign bus.tx_counter        = cnt_q;
  assign bus.tx_done           = tx_done_w;
  assign bus.sched_cmd_started = grant_sched;
  assign bus.pf_cmd_started    = grant_pf;
  assign bus.sched_data_next   = (state_q == PAYLOAD) && (owner_q == OWNER_SCHED);
  assign bus.pf_data_next      = (state_q == PAYLOAD) && (owner_q == OWNER_PF);

  tx_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (grant_sched),
    .pop       (bus.rx_done),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign bus.rx_owner_valid = !fifo_empty;
  assign bus.rx_owner_sched = !fifo_empty && fifo_head;

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
Shares the single serial TX channel between two requesters: the scheduler (instruction data/address traffic) and the prefetch unit (sequential PC reads). It arbitrates commands, serializes the header and payload onto the TX pins, and hands each requester a data-advance strobe during its payload. It also tracks outstanding reads in an owner FIFO, so the RX side knows which requester each incoming reply belongs to.

Parameters:
NSHIFT, 2, bits transferred per cycle; equals TX_CMD_BITS.
PAYLOAD_CYCLES, 8, payload cycles of a 16-bit command.
MAX_OUTSTANDING, 2, maximum reads awaiting reply; owner FIFO depth.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
sched_cmd_valid  in  1  scheduler requests a command
sched_cmd  in  TX_CMD_BITS  scheduler command code
sched_reserve  in  1  scheduler holds channel; blocks prefetch grants
sched_reply_wanted  in  1  scheduler READ expects an RX reply
sched_cmd_started  out  1  one-cycle grant strobe to scheduler
sched_data  in  NSHIFT  scheduler payload bits
sched_data_next  out  1  scheduler payload consumed this cycle
pf_cmd_valid  in  1  prefetch requests READ_16
pf_cmd_started  out  1  one-cycle grant strobe to prefetch
pf_data  in  NSHIFT  prefetch payload (address) bits
pf_data_next  out  1  prefetch payload consumed this cycle
tx_pins  out  NSHIFT  serial TX output
tx_active  out  1  frame in progress
tx_counter  out  clog2(PAYLOAD_CYCLES)+1  cycle index within frame
tx_done  out  1  last payload cycle of frame
rx_done  in  1  a read reply has fully arrived
rx_owner_valid  out  1  at least one read outstanding
rx_owner_sched  out  1  head reply belongs to scheduler (0 = prefetch)

Behaviour:
- Reset: state IDLE; tx_pins=0, tx_active=0, tx_counter=0, tx_done=0, all strobes 0, FIFO empty, rx_owner_valid=0, rx_owner_sched=0.
- Command codes: READ_16=1, WRITE_8=2, WRITE_16=3; 0 is never granted. Payload length is PAYLOAD_CYCLES/2 for WRITE_8, otherwise PAYLOAD_CYCLES.
- Arbitration runs in any cycle where state is IDLE or tx_done=1, so back-to-back frames are allowed.
  - Scheduler wins if sched_cmd_valid.
  - Otherwise prefetch wins if pf_cmd_valid && !sched_reserve.
  - A READ_16 request is ineligible while the FIFO is full, unless rx_done pops in the same cycle.
- Grant cycle:
  - Pulse the winner's *_cmd_started.
  - Latch the command and owner.
  - Push the owner to the FIFO if the command is READ_16 and a reply is wanted (prefetch always wants one).
- Frame, starting the cycle after the grant:
  - HEADER: tx_counter=0, tx_pins=cmd, tx_active=1.
  - PAYLOAD: tx_counter=1..len; tx_pins=owner data combinationally; owner *_data_next=1 every payload cycle. tx_done=1 when tx_counter==len.
  - After the last payload cycle, return to IDLE unless re-granted; pins go to 0.
- FIFO:
  - rx_done pops the head.
  - Push and pop in the same cycle keep the count.
  - rx_done while empty is ignored.
  - rx_owner_* reflect the current head.
- A requester may drop valid after its grant without effect on the frame.
- Reset mid-frame aborts the frame immediately and clears the FIFO.

Optional Feature:
TX_ARB_ROUND_ROBIN_EN
- Defined: after a scheduler grant, prefetch has priority at the next arbitration where both are eligible. Priority returns to the scheduler after any prefetch grant.
- Undefined: fixed scheduler priority; prefetch may starve.

Decomposition:
- Shared package/header holds TX_HEADER_READ_16/WRITE_8/WRITE_16 codes, TX_CMD_BITS, owner encoding (OWNER_PF=0, OWNER_SCHED=1), and state encoding (IDLE/HEADER/PAYLOAD).
- One sub-module: tx_owner_fifo (depth MAX_OUTSTANDING, 1-bit entries, push/pop/full/empty).

Test Plan:
- pf_cmd_valid alone, pf_data=2'b10 -> pf_cmd_started at T, header pins=01 at T+1, 8 payload cycles of 10, tx_done at counter 8, rx_owner_valid=1 with owner_sched=0.
- Scheduler and prefetch valid together (RR off), sched_cmd=WRITE_8 -> scheduler granted; 4 payload cycles; prefetch granted on the tx_done cycle; its header follows immediately.
- sched_reserve=1 with pf_cmd_valid=1 for 20 cycles -> no pf grant, tx_pins=0; reserve drops -> grant next cycle.
- Two prefetch READ_16 with no rx_done -> third pf request is held; rx_done in an arbitration cycle -> grant in that cycle, FIFO count stays 2.
- Scheduler READ (reply wanted) then prefetch READ -> first rx_done leaves owner_sched=0, second rx_done sets owner_valid=0; an extra rx_done is ignored.
- Reset asserted at payload cycle 3 -> next cycle tx_active=0, pins=0, FIFO empty; with RR_EN, both requesters valid continuously -> grants alternate sched, pf, sched.
